bcd_updown_counter: RTL and testbench
=====================================

// Module: bcd_updown_counter
// PURPOSE
//  Multi-digit BCD up/down counter. Produces the per-digit 4-bit values
//  consumed by the hex_decoder instances, one decoder per digit.
//  An internal prescaler turns the board clock into a count tick.
//  Supports direction control, enable/pause and parallel load.
// PARAMETERS
//  NUM_DIGITS  4           number of BCD digits (1..8)
//  CLK_HZ      50_000_000  input clock frequency
//  TICK_HZ     1           count rate; DIV = CLK_HZ/TICK_HZ, DIV >= 1
// PORTS
//  clk         in   1              single clock, all logic rising-edge
//  rst         in   1              synchronous, active-high reset
//  enable      in   1              1 = prescaler runs and counting allowed
//  up_down     in   1              1 = count up, 0 = count down
//  load        in   1              parallel load strobe, one cycle
//  load_value  in   4*NUM_DIGITS   BCD value to load; digit 0 = bits [3:0]
//  digits      out  4*NUM_DIGITS   current BCD count; digit 0 = LSD, [3:0]
//  tick        out  1              one-cycle pulse each DIV enabled cycles
//  wrap        out  1              one-cycle pulse when the count wraps
// BEHAVIOUR
//  - Reset: digits=0, tick=0, wrap=0, prescaler=0. Reset wins over all inputs.
//  - Priority after reset: load > count step > hold.
//  - Prescaler counts 0..DIV-1 only while enable=1 and holds while enable=0.
//    tick is registered and high in the cycle after the prescaler reaches DIV-1.
//    DIV=1 gives tick high in every enabled cycle. The prescaler is unaffected by load.
//  - Step: on a clock edge with tick=1 and enable=1, the count moves by 1 in
//    the up_down direction sampled on that edge. Digits are valid on the next cycle.
//  - Up: digit 9->0 carries into the next digit. All-9s -> all-0s, and wrap=1
//    for exactly one cycle.
//  - Down: digit 0->9 borrows from the next digit. All-0s -> all-9s, and wrap=1
//    for exactly one cycle.
//  - Load: digits <= load_value on the next edge. Any nibble >9 is loaded as 0.
//    A load in a tick cycle suppresses that step and wrap.
//  - Direction changes take effect at the next tick. There is no glitch step.
//  - enable=0 freezes digits and the prescaler. load still works.
//  - digits always holds valid BCD (0..9 per nibble). No X after reset.
//  - Asserting rst mid-count clears everything on the next edge. Counting
//    resumes from 0 with a full DIV period before the first tick.
// STRUCTURE
//  - Shared header counter_defs.vh: BCD_MAX=4'd9, BCD_MIN=4'd0, BCD_W=4.
//  - Sub-module bcd_digit holds one digit register with inputs
//    step_in, up, load, ld_val and outputs q[3:0], carry_out.
//    carry_out means "at 9 going up" or "at 0 going down".
//    A generate loop chains NUM_DIGITS cells: each cell's step_in is the
//    previous cell's step_in AND carry_out. The LSD gets tick&enable.
//  - wrap = the step_in that would ripple out of the MSD, registered.
//  - The prescaler and tick register live in the top module.
// TESTING (NUM_DIGITS=4, CLK_HZ=4, TICK_HZ=1 -> DIV=4)
//  1. Hold rst for 2 cycles, then enable=1, up_down=1.
//     -> digits=0000 during reset; tick every 4th cycle; 0001 after first tick.
//  2. Load 0x9998, count up 2 ticks.
//     -> 9999, then 0000 with wrap high for exactly 1 cycle.
//  3. Load 0x0001, up_down=0, 2 ticks.
//     -> 0000, then 9999 with wrap=1. Also check 0100 -> 0099 on a borrow.
//  4. enable=0 for 10 cycles mid-count.
//     -> digits and prescaler frozen; on re-enable the tick resumes at the held phase.
//  5. Assert load (0x12F4) in the same cycle as tick.
//     -> digits=1204 (0xF forced to 0); no step and no wrap that cycle.
//  6. Assert rst while a tick is pending with up_down toggling.
//     -> next cycle digits=0000, wrap=0, tick=0; next tick 4 cycles later.

Source files
------------

// File: rtl/bcd_updown_counter_pkg.sv
// Shared BCD constants and helpers for the up/down counter and its digit cells.
package bcd_updown_counter_pkg;

   localparam int         BCD_W   = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

   // A loaded nibble outside 0..9 is replaced by zero so the count is always valid BCD
   function automatic logic [BCD_W-1:0] bcdSanitize(input logic [BCD_W-1:0] nibble);
      return (nibble > BCD_MAX) ? BCD_MIN : nibble;
   endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// One BCD digit cell: holds a 0..9 value, steps up or down, and reports
// whether a step would carry (up from 9) or borrow (down from 0).
module bcd_digit
   import bcd_updown_counter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             step_in,
   input  logic             up,
   input  logic             load,
   input  logic [BCD_W-1:0] ld_val,
   output logic [BCD_W-1:0] q,
   output logic             carry_out
);

   logic [BCD_W-1:0] digitQ;
   logic [BCD_W-1:0] digitD;

   // The carry flag depends only on the held value and the direction, so the
   // next cell can decide whether this step ripples into it in the same cycle
   always_comb begin
      carry_out = up ? (digitQ == BCD_MAX) : (digitQ == BCD_MIN);
   end

   // Next value: a load replaces the digit outright, otherwise a step wraps
   // 9->0 going up or 0->9 going down, and with no step the digit holds
   always_comb begin
      digitD = digitQ;
      if (load) begin
         digitD = bcdSanitize(ld_val);
      end else if (step_in) begin
         if (up) begin
            digitD = (digitQ == BCD_MAX) ? BCD_MIN : digitQ + 4'd1;
         end else begin
            digitD = (digitQ == BCD_MIN) ? BCD_MAX : digitQ - 4'd1;
         end
      end
   end

   // Digit register; reset clears it to zero ahead of any load or step
   always_ff @(posedge clk) begin
      if (rst) begin
         digitQ <= BCD_MIN;
      end else begin
         digitQ <= digitD;
      end
   end

   assign q = digitQ;

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with a clock prescaler, pause, and parallel
// load. The digits feed one hex decoder each; digit 0 is the least significant.
module bcd_updown_counter
   import bcd_updown_counter_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int CLK_HZ     = 50_000_000,
   parameter int TICK_HZ    = 1
)
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic                        up_down,
   input  logic                        load,
   input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
   output logic [BCD_W*NUM_DIGITS-1:0] digits,
   output logic                        tick,
   output logic                        wrap
);

   localparam int            DIV      = CLK_HZ / TICK_HZ;
   localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

   logic [PW-1:0]       prescQ;
   logic [PW-1:0]       prescD;
   logic                tickQ;
   logic                tickD;
   logic                wrapQ;
   logic                wrapD;
   logic [NUM_DIGITS:0] stepChain;
   logic [NUM_DIGITS-1:0] carryChain;

   // Prescaler advances only while enabled and holds its phase when paused;
   // tick is raised for the cycle after the prescaler sits on its last value
   always_comb begin
      prescD = prescQ;
      tickD  = 1'b0;
      if (enable) begin
         tickD  = (prescQ == DIV_LAST);
         prescD = (prescQ == DIV_LAST) ? '0 : prescQ + PW'(1);
      end
   end

   // The least significant digit steps on an enabled tick unless a load
   // takes the cycle; a load therefore also suppresses any wrap
   always_comb begin
      stepChain[0] = tickQ & enable & ~load;
   end

   // Each cell steps only when every less significant cell is carrying or
   // borrowing; the step that would leave the top digit is the wrap event
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk       (clk),
         .rst       (rst),
         .step_in   (stepChain[i]),
         .up        (up_down),
         .load      (load),
         .ld_val    (load_value[i*BCD_W +: BCD_W]),
         .q         (digits[i*BCD_W +: BCD_W]),
         .carry_out (carryChain[i])
      );
      assign stepChain[i+1] = stepChain[i] & carryChain[i];
   end

   // Wrap is registered so it lines up with the cycle the rolled-over digits appear
   always_comb begin
      wrapD = stepChain[NUM_DIGITS];
   end

   // Prescaler, tick and wrap registers; reset restarts a full tick period
   always_ff @(posedge clk) begin
      if (rst) begin
         prescQ <= '0;
         tickQ  <= 1'b0;
         wrapQ  <= 1'b0;
      end else begin
         prescQ <= prescD;
         tickQ  <= tickD;
         wrapQ  <= wrapD;
      end
   end

   assign tick = tickQ;
   assign wrap = wrapQ;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter with four digits and a divide-by-4
// prescaler. A behavioural model based on an integer count predicts each
// cycle's outputs; predictions are queued when the stimulus is driven and
// retired against the DUT one clock later.
module tb_bcd_updown_counter;

   localparam int NUM_DIGITS = 4;
   localparam int CLK_HZ     = 4;
   localparam int TICK_HZ    = 1;
   localparam int DIV        = CLK_HZ / TICK_HZ;
   localparam int MAXV       = 9999;

   typedef struct packed {
      logic [15:0] digits;
      logic        tick;
      logic        wrap;
   } expect_t;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        upDown;
   logic        load;
   logic [15:0] loadValue;
   logic [15:0] digits;
   logic        tick;
   logic        wrap;

   expect_t expQ[$];
   int      total;
   int      bad;

   int      mPresc;
   int      mCnt;
   logic    mTick;
   logic    mWrap;

   bcd_updown_counter #(
      .NUM_DIGITS (NUM_DIGITS),
      .CLK_HZ     (CLK_HZ),
      .TICK_HZ    (TICK_HZ)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .up_down    (upDown),
      .load       (load),
      .load_value (loadValue),
      .digits     (digits),
      .tick       (tick),
      .wrap       (wrap)
   );

   // Free-running board clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Integer count to four BCD nibbles
   function automatic logic [15:0] toBcd(input int value);
      logic [15:0] result;
      int          rest;
      result = '0;
      rest   = value;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         result[i*4 +: 4] = 4'(rest % 10);
         rest             = rest / 10;
      end
      return result;
   endfunction

   // Load word to integer, with out-of-range nibbles read as zero
   function automatic int fromLoad(input logic [15:0] word);
      int          value;
      int          weight;
      logic [3:0]  nib;
      value  = 0;
      weight = 1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         nib    = word[i*4 +: 4];
         value  = value + ((nib > 4'd9) ? 0 : int'(nib)) * weight;
         weight = weight * 10;
      end
      return value;
   endfunction

   // Advance the model by one clock edge with the given inputs
   task automatic modelEdge(input logic r, input logic e, input logic ud,
                            input logic l, input logic [15:0] lv);
      logic stepNow;
      logic nextTick;
      logic nextWrap;
      if (r) begin
         mPresc = 0;
         mCnt   = 0;
         mTick  = 1'b0;
         mWrap  = 1'b0;
      end else begin
         stepNow  = mTick && e && !l;
         nextWrap = 1'b0;
         if (l) begin
            mCnt = fromLoad(lv);
         end else if (stepNow) begin
            if (ud) begin
               if (mCnt == MAXV) begin
                  mCnt     = 0;
                  nextWrap = 1'b1;
               end else begin
                  mCnt = mCnt + 1;
               end
            end else begin
               if (mCnt == 0) begin
                  mCnt     = MAXV;
                  nextWrap = 1'b1;
               end else begin
                  mCnt = mCnt - 1;
               end
            end
         end
         nextTick = e && (mPresc == DIV - 1);
         if (e) begin
            mPresc = (mPresc == DIV - 1) ? 0 : mPresc + 1;
         end
         mTick = nextTick;
         mWrap = nextWrap;
      end
   endtask

   // Single comparison point: counts it and reports a miss
   task automatic checkValue(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Retire the oldest prediction against the outputs the DUT now shows
   task automatic checkOutput();
      expect_t exp;
      if (expQ.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         exp = expQ.pop_front();
         checkValue("digits", digits, exp.digits);
         checkValue("tick", {15'd0, tick}, {15'd0, exp.tick});
         checkValue("wrap", {15'd0, wrap}, {15'd0, exp.wrap});
      end
   endtask

   // Drive one cycle of inputs, queue the prediction, clock, then compare
   task automatic applyStimulus(input logic r, input logic e, input logic ud,
                                input logic l, input logic [15:0] lv);
      expect_t exp;
      rst       = r;
      enable    = e;
      upDown    = ud;
      load      = l;
      loadValue = lv;
      modelEdge(r, e, ud, l, lv);
      exp.digits = toBcd(mCnt);
      exp.tick   = mTick;
      exp.wrap   = mWrap;
      expQ.push_back(exp);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   // Directed sequence
   initial begin
      int guard;
      total     = 0;
      bad       = 0;
      mPresc    = 0;
      mCnt      = 0;
      mTick     = 1'b0;
      mWrap     = 1'b0;
      rst       = 1'b1;
      enable    = 1'b0;
      upDown    = 1'b1;
      load      = 1'b0;
      loadValue = '0;
      @(negedge clk);

      $display("[TB] reset and first count up");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

      $display("[TB] up wrap from 9998");
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h9998);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

      $display("[TB] down wrap from 0001 and borrow from 0100");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'h0001);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'h0100);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      checkValue("borrow_0099", digits, 16'h0099);

      $display("[TB] pause mid-count");
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

      $display("[TB] load in a tick cycle");
      guard = 0;
      while (!mTick && guard < 20) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
         guard++;
      end
      if (!mTick) begin
         total++;
         bad++;
         $display("[TB] FAIL tick_wait observed=0 expected=1");
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h12F4);
      checkValue("load_12F4", digits, 16'h1204);
      checkValue("load_no_wrap", {15'd0, wrap}, 16'h0000);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

      $display("[TB] reset with a tick pending");
      guard = 0;
      while (mPresc != DIV - 1 && guard < 20) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
         guard++;
      end
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      checkValue("rst_digits", digits, 16'h0000);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 1'b1, logic'(i % 2), 1'b0, 16'h0000);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case the sequence never completes
   initial begin
      #100000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
